// File: rtl/decimate_avg.sv
// decimate_avg: block-average decimator for a signed sample stream.
// Each non-overlapping block of 2^log2_ratio_p accepted samples is summed.
// The block average (sum >>> log2_ratio_p) is emitted as one signed sample
// over a valid/ready handshake. The block sustains one sample per cycle.
// Optional build macro DECIMATE_AVG_ROUND_EN: adds half an LSB of the
// quotient before the shift, which gives round-half-up instead of floor.
module decimate_avg #(
  parameter int width_p      = 10,
  parameter int log2_ratio_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
);

`ifdef DECIMATE_AVG_ROUND_EN
  // One extra accumulator bit gives headroom for the rounding bias.
  localparam int round_w_lp = (log2_ratio_p > 0) ? 1 : 0;
`else
  localparam int round_w_lp = 0;
`endif

  // A full block plus optional bias always fits in this width.
  localparam int acc_w_lp = width_p + log2_ratio_p + round_w_lp;

  // Output register and handshake qualifiers.
  logic               valid_q, valid_d;
  logic [width_p-1:0] data_q, data_d;
  logic               is_final;    // the next accepted sample closes a block
  logic [width_p-1:0] avg_w;       // average including the sample on data_i
  logic               accept;
  logic               consume;

  // A final sample may enter only if the output slot is free or draining.
  // Non-final samples only touch the accumulator, so they are always taken.
  // There is intentionally no path from valid_i to ready_o.
  assign ready_o = is_final ? (~valid_q | ready_i) : 1'b1;
  assign accept  = valid_i & ready_o;
  assign consume = valid_q & ready_i;

  generate
    if (log2_ratio_p > 0) begin : g_accum
      localparam logic [log2_ratio_p-1:0] cnt_last_lp = '1;
      localparam logic [log2_ratio_p-1:0] cnt_one_lp  = log2_ratio_p'(1);

      logic [log2_ratio_p-1:0]    count_q, count_d;
      logic signed [acc_w_lp-1:0] acc_q, acc_d;
      logic signed [acc_w_lp-1:0] sample_w;
      logic signed [acc_w_lp-1:0] sum_w;
      logic signed [acc_w_lp-1:0] biased_w;

      assign is_final = (count_q == cnt_last_lp);
      assign sample_w = {{(acc_w_lp-width_p){data_i[width_p-1]}}, data_i};
      assign sum_w    = acc_q + sample_w;

`ifdef DECIMATE_AVG_ROUND_EN
      // Half of the divisor pushes ties up toward +inf.
      localparam logic signed [acc_w_lp-1:0] round_bias_lp =
        acc_w_lp'(1) << (log2_ratio_p - 1);
      assign biased_w = sum_w + round_bias_lp;
`else
      assign biased_w = sum_w;
`endif

      // Arithmetic shift floors toward -inf; the result always fits width_p.
      assign avg_w = width_p'(biased_w >>> log2_ratio_p);

      // Accumulate non-final samples; clear and wrap on the final one.
      always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        if (accept) begin
          if (is_final) begin
            acc_d   = '0;
            count_d = '0;
          end else begin
            acc_d   = sum_w;
            count_d = count_q + cnt_one_lp;
          end
        end
      end

      // Accumulator and sample-counter state; reset drops a partial block.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          acc_q   <= '0;
          count_q <= '0;
        end else begin
          acc_q   <= acc_d;
          count_q <= count_d;
        end
      end
    end else begin : g_pass
      // Ratio 1: every sample is final and passes straight through.
      assign is_final = 1'b1;
      assign avg_w    = data_i;
    end
  endgenerate

  // Load a new average on a final accept (also when the old one is consumed
  // in the same cycle); otherwise clear valid on consume and hold the data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (accept && is_final) begin
      valid_d = 1'b1;
      data_d  = avg_w;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  // Output register; reset also discards an unconsumed result.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
